// File: rtl/button_ctrl_if.sv
// Push-button bus: raw button levels in, conditioned levels and event pulses out.
interface button_ctrl_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output btn_repeat
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  btn_repeat
    );
endinterface

// File: rtl/button_ctrl.sv
// Push-button synchroniser/debouncer producing press, release, long and repeat pulses.
// Auto-repeat is built only when BTN_REPEAT_EN is defined; otherwise btn_repeat is tied low.
module button_ctrl #(
    parameter int N_BTN       = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input logic          clk,
    input logic          rst,
    button_ctrl_if.master bus
);
    localparam int DBW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW  = $clog2(LONG_MS + 1);
    localparam logic [DBW-1:0] DB_TERM   = DBW'(DEBOUNCE_MS);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0]  HOLD_SAT  = HW'(LONG_MS);
`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_MS + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_MS - 1);
`endif

    typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, LONG, DB_RELEASE} state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
    logic [N_BTN-1:0] long_v;
    logic [N_BTN-1:0] repeat_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t         state_q, state_d;
        logic           origin_long_q, origin_long_d;
        logic [DBW-1:0] db_q, db_d;
        logic [HW-1:0]  hold_q, hold_d;
        logic           level_q, level_d;
        logic           press_q, press_d;
        logic           release_q, release_d;
        logic           long_q, long_d;
        logic           repeat_q, repeat_d;
        logic           hold_step;
        logic           in_long;
        logic           s;
`ifdef BTN_REPEAT_EN
        logic [RW-1:0]  rpt_q, rpt_d;
`endif

        assign s = sync2[i];

        always_comb begin
            state_d       = state_q;
            origin_long_d = origin_long_q;
            db_d          = db_q;
            hold_d        = hold_q;
            press_d       = 1'b0;
            release_d     = 1'b0;
            long_d        = 1'b0;
            repeat_d      = 1'b0;
            hold_step     = 1'b0;
            in_long       = (state_q == LONG);
`ifdef BTN_REPEAT_EN
            rpt_d         = rpt_q;
`endif
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = DB_PRESS;
                        db_d    = DBW'(1);
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (db_q == DB_TERM) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                PRESSED, LONG: begin
                    if (!s) begin
                        state_d       = DB_RELEASE;
                        origin_long_d = (state_q == LONG);
                        db_d          = DBW'(1);
                    end else begin
                        hold_step = 1'b1;
                    end
                end
                DB_RELEASE: begin
                    if (s) begin
                        hold_step = 1'b1;
                        in_long   = origin_long_q;
                    end else if (db_q == DB_TERM) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
`ifdef BTN_REPEAT_EN
                        rpt_d     = '0;
`endif
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // A cancelled release resumes the held state on the same edge, so a glitch
            // delays long/repeat by exactly the number of cycles the button read low.
            if (hold_step) begin
                if (!in_long) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                        hold_d  = HOLD_SAT;
`ifdef BTN_REPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        state_d = PRESSED;
                        hold_d  = hold_q + 1'b1;
                    end
                end else begin
                    state_d = LONG;
`ifdef BTN_REPEAT_EN
                    if (rpt_q == RPT_LAST) begin
                        repeat_d = 1'b1;
                        rpt_d    = '0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
`endif
                end
            end

            level_d = (state_d == PRESSED) || (state_d == LONG) || (state_d == DB_RELEASE);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q       <= IDLE;
                origin_long_q <= 1'b0;
                db_q          <= '0;
                hold_q        <= '0;
                level_q       <= 1'b0;
                press_q       <= 1'b0;
                release_q     <= 1'b0;
                long_q        <= 1'b0;
                repeat_q      <= 1'b0;
`ifdef BTN_REPEAT_EN
                rpt_q         <= '0;
`endif
            end else begin
                state_q       <= state_d;
                origin_long_q <= origin_long_d;
                db_q          <= db_d;
                hold_q        <= hold_d;
                level_q       <= level_d;
                press_q       <= press_d;
                release_q     <= release_d;
                long_q        <= long_d;
                repeat_q      <= repeat_d;
`ifdef BTN_REPEAT_EN
                rpt_q         <= rpt_d;
`endif
            end
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
        assign long_v[i]    = long_q;
        assign repeat_v[i]  = repeat_q;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_long    = long_v;
`ifdef BTN_REPEAT_EN
    assign bus.btn_repeat  = repeat_v;
`else
    assign bus.btn_repeat  = '0;
`endif
endmodule
